// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: opcode constants, fetch state encoding
// and instruction-size encodings (the size encodings are also used by the decoder).
package fetch_unit_pkg;

  localparam logic [7:0] OPC_JMP_ABS = 8'h4C;
  localparam logic [7:0] OPC_NOP     = 8'hEA;

  localparam logic [1:0] SIZE_1 = 2'd1;
  localparam logic [1:0] SIZE_2 = 2'd2;
  localparam logic [1:0] SIZE_3 = 2'd3;

  typedef enum logic [1:0] {
    FETCH_OP = 2'd0,
    FETCH_B1 = 2'd1,
    FETCH_B2 = 2'd2,
    ISSUE    = 2'd3
  } fetch_state_e;

  // The decoder may report 0 for unknown opcodes; fetch treats that as a 1-byte instruction.
  function automatic logic [1:0] norm_size(input logic [1:0] raw);
    return (raw == 2'd0) ? SIZE_1 : raw;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: reads opcode plus 0-2 operand bytes and issues one
// assembled instruction via valid/ready. Define FETCH_JMP_FOLD_EN to fold JMP abs in fetch.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0200
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic [7:0]        dec_opcode,
  input  logic [1:0]        dec_instr_size,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_opcode,
  output logic [7:0]        instr_op1,
  output logic [7:0]        instr_op2,
  output logic [1:0]        instr_size,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [7:0]        instr_opcode_q, instr_opcode_d;
  logic [7:0]        op1_q, op1_d;
  logic [7:0]        op2_q, op2_d;
  logic [1:0]        size_q, size_d;

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path infers a latch.
    state_d        = state_q;
    pc_d           = pc_q;
    instr_pc_d     = instr_pc_q;
    opcode_d       = opcode_q;
    instr_opcode_d = instr_opcode_q;
    op1_d          = op1_q;
    op2_d          = op2_q;
    size_d         = size_q;

    if (redirect_valid) begin
      // Redirect wins over any memory completion or handshake in the same cycle.
      state_d = FETCH_OP;
      pc_d    = redirect_pc;
    end else begin
      case (state_q)
        FETCH_OP: if (mem_ready) begin
          opcode_d       = mem_rdata;
          instr_opcode_d = mem_rdata;
          instr_pc_d     = pc_q;
          pc_d           = pc_q + 1'b1;
          size_d         = norm_size(dec_instr_size);
          state_d        = (norm_size(dec_instr_size) == SIZE_1) ? ISSUE : FETCH_B1;
        end
        FETCH_B1: if (mem_ready) begin
          op1_d   = mem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = (size_q == SIZE_3) ? FETCH_B2 : ISSUE;
        end
        FETCH_B2: if (mem_ready) begin
          op2_d   = mem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = ISSUE;
`ifdef FETCH_JMP_FOLD_EN
          if (opcode_q == OPC_JMP_ABS) begin
            pc_d    = ADDR_W'({mem_rdata, op1_q});
            state_d = FETCH_OP;
          end
`else
`endif
        end
        ISSUE: if (instr_ready) state_d = FETCH_OP;
      endcase
    end

    if (state_d == FETCH_OP) begin
      op1_d = 8'h00;
      op2_d = 8'h00;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FETCH_OP;
      pc_q           <= RESET_PC;
      instr_pc_q     <= RESET_PC;
      opcode_q       <= OPC_NOP;
      instr_opcode_q <= 8'h00;
      op1_q          <= 8'h00;
      op2_q          <= 8'h00;
      size_q         <= SIZE_1;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instr_pc_q     <= instr_pc_d;
      opcode_q       <= opcode_d;
      instr_opcode_q <= instr_opcode_d;
      op1_q          <= op1_d;
      op2_q          <= op2_d;
      size_q         <= size_d;
    end
  end

  // Request is masked while reset is held so nothing is read before release.
  assign mem_rd       = rst_n && (state_q != ISSUE);
  assign mem_addr     = pc_q;
  assign dec_opcode   = (state_q == FETCH_OP && mem_ready) ? mem_rdata : opcode_q;
  assign instr_valid  = (state_q == ISSUE);
  assign instr_opcode = instr_opcode_q;
  assign instr_op1    = op1_q;
  assign instr_op2    = op2_q;
  assign instr_size   = size_q;
  assign instr_pc     = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: byte memory and decoder size table live here,
// expected instructions come from an instruction-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [7:0]  dec_opcode;
  logic [1:0]  dec_instr_size;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode, instr_op1, instr_op2;
  logic [1:0]  instr_size;
  logic [15:0] instr_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  logic [7:0]  mem [0:65535];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [1:0] dec_size(input logic [7:0] opc);
    case (opc)
      8'h4C, 8'h8D: return 2'd3;
      8'hA9:        return 2'd2;
      8'hE8, 8'hEA: return 2'd1;
      8'h00:        return 2'd0;
      default:      return 2'(opc % 8'd3) + 2'd1;
    endcase
  endfunction

  assign mem_rdata      = mem[mem_addr];
  assign dec_instr_size = dec_size(dec_opcode);

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dec_opcode(dec_opcode), .dec_instr_size(dec_instr_size),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_op1(instr_op1), .instr_op2(instr_op2),
    .instr_size(instr_size), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  function automatic logic [41:0] obs_instr();
    return {instr_opcode, instr_op1, instr_op2, instr_size, instr_pc};
  endfunction

  // Instruction-level reference: what the next instruction at pc should look like.
  task automatic model_next(input logic [15:0] pc, output logic [41:0] exp,
                            output logic [15:0] npc, output bit folded);
    logic [7:0]  opc, b1, b2;
    logic [1:0]  sz;
    logic [15:0] a1, a2;
    opc = mem[pc];
    sz  = dec_size(opc);
    if (sz == 2'd0) sz = 2'd1;
    a1 = pc + 16'd1;
    a2 = pc + 16'd2;
    b1 = (sz >= 2'd2) ? mem[a1] : 8'h00;
    b2 = (sz == 2'd3) ? mem[a2] : 8'h00;
    exp    = {opc, b1, b2, sz, pc};
    npc    = pc + {14'd0, sz};
    folded = 1'b0;
`ifdef FETCH_JMP_FOLD_EN
    if (opc == 8'h4C && sz == 2'd3) begin
      folded = 1'b1;
      npc    = {b2, b1};
    end
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [15:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  // Runs until execute accepts an instruction; returns what was accepted.
  task automatic collect_issue(input int budget, input bit rand_mr, input bit rand_ir,
                               output bit ok, output logic [41:0] obs);
    ok  = 1'b0;
    obs = '0;
    for (int i = 0; i < budget; i++) begin
      mem_ready   = rand_mr ? 1'($urandom_range(0, 1)) : 1'b1;
      instr_ready = rand_ir ? 1'($urandom_range(0, 1)) : 1'b1;
      if (instr_valid && instr_ready) begin
        obs = obs_instr();
        ok  = 1'b1;
        step();
        break;
      end
      step();
    end
    mem_ready   = 1'b1;
    instr_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'h0000;
    repeat (3) step();
    n_cmp++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL reset_mem_rd got %b want 0", mem_rd); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    n_cmp++; if (mem_addr !== 16'h0200) begin n_err++; $display("FAIL reset_addr got %h want 0200", mem_addr); end
    n_cmp++; if (obs_instr() !== {8'h00, 8'h00, 8'h00, 2'd1, 16'h0200}) begin n_err++; $display("FAIL reset_fields got %h want %h", obs_instr(), {8'h00, 8'h00, 8'h00, 2'd1, 16'h0200}); end
    n_cmp++; if (dec_opcode !== 8'hEA) begin n_err++; $display("FAIL reset_dec_opcode got %h want ea", dec_opcode); end
  endtask

  task automatic test_single_byte();
    mem[16'h0200] = 8'hE8;
    mem[16'h0201] = 8'hEA;
    mem_ready = 1'b1; instr_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (mem_rd !== 1'b1) begin n_err++; $display("FAIL release_mem_rd got %b want 1", mem_rd); end
    step();
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL single_latency got %b want 1", instr_valid); end
    n_cmp++; if (obs_instr() !== {8'hE8, 8'h00, 8'h00, 2'd1, 16'h0200}) begin n_err++; $display("FAIL single_fields got %h want %h", obs_instr(), {8'hE8, 8'h00, 8'h00, 2'd1, 16'h0200}); end
    n_cmp++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL single_issue_rd got %b want 0", mem_rd); end
    step();
    n_cmp++; if (mem_addr !== 16'h0201) begin n_err++; $display("FAIL single_next_addr got %h want 0201", mem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_drop got %b want 0", instr_valid); end
  endtask

  task automatic test_two_byte();
    bit ok; logic [41:0] obs;
    mem[16'h0300] = 8'hA9;
    mem[16'h0301] = 8'h42;
    do_redirect(16'h0300);
    collect_issue(20, 1'b0, 1'b0, ok, obs);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL two_byte_timeout got none want issue"); end
    n_cmp++; if (obs !== {8'hA9, 8'h42, 8'h00, 2'd2, 16'h0300}) begin n_err++; $display("FAIL two_byte got %h want %h", obs, {8'hA9, 8'h42, 8'h00, 2'd2, 16'h0300}); end
  endtask

  task automatic test_jmp();
    mem[16'h0400] = 8'h4C;
    mem[16'h0401] = 8'h34;
    mem[16'h0402] = 8'h12;
    mem[16'h1234] = 8'hEA;
    mem_ready = 1'b1; instr_ready = 1'b0;
    do_redirect(16'h0400);
    repeat (3) step();
`ifdef FETCH_JMP_FOLD_EN
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL jmp_fold_no_issue got %b want 0", instr_valid); end
    n_cmp++; if (mem_addr !== 16'h1234) begin n_err++; $display("FAIL jmp_fold_addr got %h want 1234", mem_addr); end
    n_cmp++; if (mem_rd !== 1'b1) begin n_err++; $display("FAIL jmp_fold_rd got %b want 1", mem_rd); end
`else
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL jmp_latency got %b want 1", instr_valid); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (obs_instr() !== {8'h4C, 8'h34, 8'h12, 2'd3, 16'h0400} || mem_rd !== 1'b0 || instr_valid !== 1'b1) begin
        n_err++; $display("FAIL jmp_hold cycle %0d got %h rd %b v %b want %h rd 0 v 1", i, obs_instr(), mem_rd, instr_valid, {8'h4C, 8'h34, 8'h12, 2'd3, 16'h0400});
      end
      step();
    end
    instr_ready = 1'b1;
    step();
    n_cmp++; if (instr_valid !== 1'b0 || mem_addr !== 16'h0403) begin n_err++; $display("FAIL jmp_accept got v %b addr %h want v 0 addr 0403", instr_valid, mem_addr); end
`endif
    instr_ready = 1'b1;
  endtask

  task automatic test_stall();
    bit ok; logic [41:0] obs; int reads;
    mem[16'h0600] = 8'h8D;
    mem[16'h0601] = 8'hC1;
    mem[16'h0602] = 8'hC2;
    instr_ready = 1'b1; mem_ready = 1'b1;
    do_redirect(16'h0600);
    ok = 1'b0; obs = '0; reads = 0;
    for (int i = 0; i < 80; i++) begin
      if (instr_valid) begin ok = 1'b1; obs = obs_instr(); break; end
      n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0600 + 16'(reads)) begin
        n_err++; $display("FAIL stall_addr got rd %b addr %h want rd 1 addr %h", mem_rd, mem_addr, 16'h0600 + 16'(reads));
      end
      mem_ready = 1'($urandom_range(0, 1));
      if (mem_ready) reads++;
      step();
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_timeout got none want issue"); end
    n_cmp++; if (obs !== {8'h8D, 8'hC1, 8'hC2, 2'd3, 16'h0600}) begin n_err++; $display("FAIL stall_result got %h want %h", obs, {8'h8D, 8'hC1, 8'hC2, 2'd3, 16'h0600}); end
    mem_ready = 1'b1;
    step();
  endtask

  task automatic test_redirect();
    bit ok; logic [41:0] obs;
    mem[16'h0700] = 8'h8D; mem[16'h0701] = 8'h11; mem[16'h0702] = 8'h22;
    mem[16'h0500] = 8'hA9; mem[16'h0501] = 8'h77;
    mem_ready = 1'b1; instr_ready = 1'b1;
    do_redirect(16'h0700);
    step();
    do_redirect(16'h0500);
    n_cmp++; if (mem_addr !== 16'h0500 || mem_rd !== 1'b1 || instr_valid !== 1'b0 || instr_op1 !== 8'h00) begin
      n_err++; $display("FAIL redirect_b1 got addr %h rd %b v %b op1 %h want 0500 1 0 00", mem_addr, mem_rd, instr_valid, instr_op1);
    end
    collect_issue(20, 1'b0, 1'b0, ok, obs);
    n_cmp++; if (!ok || obs !== {8'hA9, 8'h77, 8'h00, 2'd2, 16'h0500}) begin n_err++; $display("FAIL redirect_target got %h ok %b want %h", obs, ok, {8'hA9, 8'h77, 8'h00, 2'd2, 16'h0500}); end
    instr_ready = 1'b0;
    do_redirect(16'h0500);
    repeat (2) step();
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL redirect_issue_reach got %b want 1", instr_valid); end
    do_redirect(16'h0200);
    n_cmp++; if (instr_valid !== 1'b0 || mem_addr !== 16'h0200) begin n_err++; $display("FAIL redirect_issue_drop got v %b addr %h want 0 0200", instr_valid, mem_addr); end
    instr_ready = 1'b1;
  endtask

  task automatic test_wrap_and_reset();
    bit ok; logic [41:0] obs;
    mem[16'hFFFF] = 8'hA9;
    mem[16'h0000] = 8'h5A;
    mem_ready = 1'b1; instr_ready = 1'b1;
    do_redirect(16'hFFFF);
    collect_issue(20, 1'b0, 1'b0, ok, obs);
    n_cmp++; if (!ok || obs !== {8'hA9, 8'h5A, 8'h00, 2'd2, 16'hFFFF}) begin n_err++; $display("FAIL wrap got %h ok %b want %h", obs, ok, {8'hA9, 8'h5A, 8'h00, 2'd2, 16'hFFFF}); end
    n_cmp++; if (mem_addr !== 16'h0001) begin n_err++; $display("FAIL wrap_next got %h want 0001", mem_addr); end
    do_redirect(16'h0700);
    repeat (2) step();
    mem_ready = 1'b0;
    n_cmp++; if (instr_op1 !== 8'h11 || mem_addr !== 16'h0702) begin n_err++; $display("FAIL midreset_pre got op1 %h addr %h want 11 0702", instr_op1, mem_addr); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (instr_valid !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 16'h0200 || instr_op1 !== 8'h00 || instr_size !== 2'd1 || instr_pc !== 16'h0200) begin
      n_err++; $display("FAIL midreset_vals got v %b rd %b addr %h op1 %h sz %0d pc %h", instr_valid, mem_rd, mem_addr, instr_op1, instr_size, instr_pc);
    end
    step();
    rst_n = 1'b1;
    collect_issue(20, 1'b0, 1'b0, ok, obs);
    n_cmp++; if (!ok || obs !== {8'hE8, 8'h00, 8'h00, 2'd1, 16'h0200}) begin n_err++; $display("FAIL midreset_refetch got %h ok %b want %h", obs, ok, {8'hE8, 8'h00, 8'h00, 2'd1, 16'h0200}); end
  endtask

  task automatic test_size_zero();
    bit ok; logic [41:0] obs;
    mem[16'h0800] = 8'h00;
    mem[16'h0801] = 8'hE8;
    do_redirect(16'h0800);
    collect_issue(20, 1'b0, 1'b0, ok, obs);
    n_cmp++; if (!ok || obs !== {8'h00, 8'h00, 8'h00, 2'd1, 16'h0800}) begin n_err++; $display("FAIL size_zero got %h ok %b want %h", obs, ok, {8'h00, 8'h00, 8'h00, 2'd1, 16'h0800}); end
    collect_issue(20, 1'b0, 1'b0, ok, obs);
    n_cmp++; if (!ok || obs !== {8'hE8, 8'h00, 8'h00, 2'd1, 16'h0801}) begin n_err++; $display("FAIL size_zero_next got %h ok %b want %h", obs, ok, {8'hE8, 8'h00, 8'h00, 2'd1, 16'h0801}); end
  endtask

  task automatic test_random_stream();
    bit ok, folded; logic [41:0] obs, exp; logic [15:0] pc, npc;
    for (int run = 0; run < 3; run++) begin
      pc = 16'($urandom);
      do_redirect(pc);
      for (int k = 0; k < 25; k++) begin
        model_next(pc, exp, npc, folded);
        if (folded) begin pc = npc; continue; end
        collect_issue(60, 1'b1, 1'b1, ok, obs);
        n_cmp++; if (!ok || obs !== exp) begin n_err++; $display("FAIL random run %0d instr %0d got %h ok %b want %h", run, k, obs, ok, exp); end
        pc = npc;
      end
    end
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 65536; i++) begin
      b = 8'($urandom);
      mem[i] = (b == 8'h4C) ? 8'hEA : b;
    end
    test_reset();
    test_single_byte();
    test_two_byte();
    test_jmp();
    test_stall();
    test_redirect();
    test_wrap_and_reset();
    test_size_zero();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
